load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/load_align.sv | 29 ++
 rtl/load_store_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_t    - controller state encoding
//   LSU_*          - funct3 size codes
//   f3_illegal()   - funct3 legality check (store sizes are b/h/w only)
//   f3_misaligned()- natural-alignment check for half/word accesses
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (wr && f3[2]);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (((f3 == LSU_H) || (f3 == LSU_HU)) && a[0]) ||
               ((f3 == LSU_W) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational load-data extraction and extension.
//   rdata  in  32 - raw word from memory
//   addr   in  2  - byte offset within the word
//   funct3 in  3  - size code
//   result out 32 - right-justified, sign/zero-extended load value
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            LSU_B:   result = {{24{shifted[7]}}, shifted[7:0]};
            LSU_H:   result = {{16{shifted[15]}}, shifted[15:0]};
            LSU_BU:  result = {24'd0, shifted[7:0]};
            LSU_HU:  result = {16'd0, shifted[15:0]};
            LSU_W:   result = shifted;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store controller between the core
// and a gnt/rvalid memory port.
//   clk, reset (async, active-low)
//   req_valid/req_write/req_funct3/req_addr/req_wdata - core request
//   stall, rsp_valid, rsp_rdata, err                  - core response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata          - memory request
//   mem_gnt/mem_rvalid/mem_rdata                      - memory response
//
// state | meaning
// IDLE  | waiting for a request; bad requests are answered here with err
// REQ   | mem_req held from registers until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// DONE  | one-cycle rsp_valid, core released
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            addr_lo_q;
    logic [3:0]            be_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    logic                  req_ok, accept, reject, capture;
    logic [3:0]            be_d;
    logic [31:0]           wdata_d;
    logic [31:0]           align_out;

    load_align u_align (
        .rdata  (mem_rdata),
        .addr   (addr_lo_q),
        .funct3 (f3_q),
        .result (align_out)
    );

    always_comb begin
        req_ok = !f3_illegal(req_funct3, req_write) &&
                 !f3_misaligned(req_funct3, req_addr[1:0]);
        // The request decode is combinational from core inputs, so it is
        // gated by reset to keep stall/err low while reset is asserted.
        accept = reset && (state_q == IDLE) && req_valid && req_ok;
        reject = reset && (state_q == IDLE) && req_valid && !req_ok;
        capture = !we_q && mem_rvalid &&
                  (((state_q == REQ) && mem_gnt) || (state_q == WAIT));

        be_d    = 4'b1111;
        wdata_d = 32'd0;
        if (req_write) begin
            case (req_funct3)
                LSU_B: begin
                    be_d    = 4'b0001 << req_addr[1:0];
                    wdata_d = {4{req_wdata[7:0]}};
                end
                LSU_H: begin
                    be_d    = 4'b0011 << {req_addr[1], 1'b0};
                    wdata_d = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (mem_gnt) begin
                    if (we_q || mem_rvalid) state_d = DONE;
                    else                    state_d = WAIT;
                end
            end
            WAIT: if (mem_rvalid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_lo_q <= 2'd0;
            be_q      <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q      <= req_write;
                f3_q      <= req_funct3;
                addr_lo_q <= req_addr[1:0];
                be_q      <= be_d;
                addr_q    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                wdata_q   <= wdata_d;
                rdata_q   <= 32'd0;
            end else if (capture) begin
                rdata_q <= align_out;
            end
        end
    end

    assign stall     = accept || (state_q == REQ) || (state_q == WAIT);
    assign err       = reject;
    assign rsp_valid = reject || (state_q == DONE);
    assign rsp_rdata = (state_q == DONE) ? rdata_q : 32'd0;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q && (state_q == REQ);
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
